// File: rtl/lifo_arbiter_if.sv
// Requester-side bus of lifo_arbiter: two requesters share one request
// channel (valid/ready per requester) and one response channel
// (valid/ready per requester, shared data/error).
//   master : driven by the requesters (testbench or upstream logic)
//   slave  : seen by lifo_arbiter
// Signal suffixes follow the arbiter's point of view (_i = into arbiter).
interface lifo_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [1:0]            req_valid_i;
  logic [1:0]            req_pop_i;
  logic [DATA_WIDTH-1:0] req_data0_i;
  logic [DATA_WIDTH-1:0] req_data1_i;
  logic [1:0]            req_ready_o;
  logic [1:0]            resp_valid_o;
  logic [1:0]            resp_ready_i;
  logic [DATA_WIDTH-1:0] resp_data_o;
  logic                  resp_error_o;

  modport master (
    output req_valid_i, req_pop_i, req_data0_i, req_data1_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_error_o
  );

  modport slave (
    input  req_valid_i, req_pop_i, req_data0_i, req_data1_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_error_o
  );
endinterface

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: round-robin arbiter giving two requesters push/pop access to
// an external LIFO stack, one transaction in flight at a time.
// Ports:
//   clk          - clock, all state on rising edge
//   reset        - asynchronous active-low reset
//   bus          - requester request/response bus (lifo_arbiter_if.slave)
//   lifo_push_o  - stack push strobe, lifo_data_o is the pushed word
//   lifo_pop_o   - stack pop strobe
//   lifo_read_o  - top-of-stack read strobe, lifo_data_i valid same cycle
//   lifo_data_o  - stack write data
//   lifo_data_i  - stack top-of-stack data
//   lifo_empty_i - stack empty status
//   lifo_full_i  - stack full status
// Flow: IDLE (arbitrate/accept) -> ISSUE (one stack strobe or error) ->
// RESP (hold response until the owning requester accepts it).
module lifo_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  lifo_arbiter_if.slave         bus,
  output logic                  lifo_push_o,
  output logic                  lifo_pop_o,
  output logic                  lifo_read_o,
  output logic [DATA_WIDTH-1:0] lifo_data_o,
  input  logic [DATA_WIDTH-1:0] lifo_data_i,
  input  logic                  lifo_empty_i,
  input  logic                  lifo_full_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;     // requester holding priority on a tie
  logic                  id_q, id_d;       // owner of the outstanding transaction
  logic                  op_q, op_d;       // 1 = pop, 0 = push
  logic [DATA_WIDTH-1:0] data_q, data_d;   // latched push data
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d; // response data
  logic                  err_q, err_d;     // response error flag
  logic [1:0]            grant;

  // A lone requester always wins; on a tie the pointer decides.
  always_comb begin
    grant = '0;
    case (bus.req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    id_d             = id_q;
    op_d             = op_q;
    data_d           = data_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    bus.req_ready_o  = '0;
    bus.resp_valid_o = '0;
    bus.resp_data_o  = '0;
    bus.resp_error_o = 1'b0;
    lifo_push_o      = 1'b0;
    lifo_pop_o       = 1'b0;
    lifo_read_o      = 1'b0;
    lifo_data_o      = '0;

    case (state_q)
      IDLE: begin
        // The grant reaches req_ready_o combinationally, so it is masked
        // while reset is asserted to keep ready low during reset.
        if (reset) begin
          bus.req_ready_o = grant;
        end
        if (grant != 2'b00) begin
          id_d    = grant[1];
          op_d    = bus.req_pop_i[grant[1]];
          data_d  = grant[1] ? bus.req_data1_i : bus.req_data0_i;
          ptr_d   = ~grant[1];
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (op_q) begin
          if (lifo_empty_i) begin
            err_d = 1'b1;
          end else begin
            lifo_pop_o  = 1'b1;
            lifo_read_o = 1'b1;
            rdata_d     = lifo_data_i;
          end
        end else begin
          if (lifo_full_i) begin
            err_d = 1'b1;
          end else begin
            lifo_push_o = 1'b1;
            lifo_data_o = data_q;
          end
        end
        state_d = RESP;
      end

      RESP: begin
        bus.resp_valid_o[id_q] = 1'b1;
        bus.resp_data_o        = rdata_q;
        bus.resp_error_o       = err_q;
        if (bus.resp_ready_i[id_q]) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
module tb_lifo_arbiter;
  localparam int unsigned DW    = 32;
  localparam int          DEPTH = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          lifo_push_o, lifo_pop_o, lifo_read_o;
  logic [DW-1:0] lifo_data_o;
  logic [DW-1:0] lifo_data_i  = '0;
  logic          lifo_empty_i = 1'b1;
  logic          lifo_full_i  = 1'b0;

  lifo_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  lifo_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .lifo_push_o  (lifo_push_o),
    .lifo_pop_o   (lifo_pop_o),
    .lifo_read_o  (lifo_read_o),
    .lifo_data_o  (lifo_data_o),
    .lifo_data_i  (lifo_data_i),
    .lifo_empty_i (lifo_empty_i),
    .lifo_full_i  (lifo_full_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stack emulation driven by the DUT strobes.
  logic [DW-1:0] mem [DEPTH];
  int            sp = 0;

  // Transaction-level reference model.
  int            m_ptr = 0;     // tie-break winner
  bit            m_out = 0;     // a transaction is outstanding
  int            m_age = 0;     // cycles since acceptance
  int            m_id  = 0;
  bit            m_pop = 0;
  logic [DW-1:0] m_data  = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_rerr  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_stack();
    lifo_empty_i = (sp == 0);
    lifo_full_i  = (sp == DEPTH);
    lifo_data_i  = (sp > 0) ? mem[sp-1] : '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, DW'(bus.req_ready_o), '0);
    check({tag, "_resp_valid"}, DW'(bus.resp_valid_o), '0);
    check({tag, "_resp_data"}, bus.resp_data_o, '0);
    check({tag, "_resp_error"}, DW'(bus.resp_error_o), '0);
    check({tag, "_lifo_strobes"}, DW'({lifo_push_o, lifo_pop_o, lifo_read_o}), '0);
    check({tag, "_lifo_data"}, lifo_data_o, '0);
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic step(input logic [1:0] v, input logic [1:0] p, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic [1:0] rr);
    logic [1:0]    exp_rdy, exp_rv;
    logic          e_push, e_pop, o_push, o_pop;
    logic [DW-1:0] o_ldata;
    int            win;
    bus.req_valid_i  = v;
    bus.req_pop_i    = p;
    bus.req_data0_i  = d0;
    bus.req_data1_i  = d1;
    bus.resp_ready_i = rr;
    drive_stack();
    #1;
    win = -1;
    if (!m_out) begin
      if (v == 2'b11)      win = m_ptr;
      else if (v == 2'b01) win = 0;
      else if (v == 2'b10) win = 1;
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    e_push = 1'b0;
    e_pop  = 1'b0;
    if (m_out && m_age == 1) begin
      m_rdata = '0;
      m_rerr  = 0;
      if (m_pop) begin
        if (sp == 0) m_rerr = 1;
        else begin
          e_pop   = 1'b1;
          m_rdata = mem[sp-1];
        end
      end else begin
        if (sp == DEPTH) m_rerr = 1;
        else e_push = 1'b1;
      end
    end
    exp_rv = '0;
    if (m_out && m_age >= 2) exp_rv[m_id] = 1'b1;

    check("req_ready", DW'(bus.req_ready_o), DW'(exp_rdy));
    check("lifo_push", DW'(lifo_push_o), DW'(e_push));
    check("lifo_pop", DW'(lifo_pop_o), DW'(e_pop));
    check("lifo_read", DW'(lifo_read_o), DW'(e_pop));
    if (e_push) check("lifo_data", lifo_data_o, m_data);
    check("resp_valid", DW'(bus.resp_valid_o), DW'(exp_rv));
    if (exp_rv != 2'b00) begin
      check("resp_data", bus.resp_data_o, m_rdata);
      check("resp_error", DW'(bus.resp_error_o), DW'(m_rerr));
    end
    o_push  = lifo_push_o;
    o_pop   = lifo_pop_o;
    o_ldata = lifo_data_o;

    @(posedge clk);
    #1;
    if (o_push && sp < DEPTH) begin
      mem[sp] = o_ldata;
      sp++;
    end else if (o_pop && sp > 0) begin
      sp--;
    end
    if (m_out) begin
      if (m_age >= 2 && rr[m_id]) m_out = 0;
      else m_age++;
    end else if (win >= 0) begin
      m_out  = 1;
      m_age  = 1;
      m_id   = win;
      m_pop  = p[win];
      m_data = (win == 1) ? d1 : d0;
      m_ptr  = 1 - win;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (m_out && n < 20) begin
      step(2'b00, 2'b00, '0, '0, 2'b11);
      n++;
    end
    if (m_out) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bus.req_valid_i  = 2'b11;
    bus.req_pop_i    = '0;
    bus.req_data0_i  = '0;
    bus.req_data1_i  = '0;
    bus.resp_ready_i = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    bus.req_valid_i = '0;
    reset = 1'b1;
    @(negedge clk);

    // Req0 push on empty stack, accepted on first edge after reset.
    sp = 0;
    step(2'b01, 2'b00, 32'hA5A5_0001, '0, 2'b00);
    step(2'b00, 2'b00, '0, '0, 2'b00);
    step(2'b00, 2'b00, '0, '0, 2'b01);
    drain();

    // Req1 pop with known top of stack.
    sp = 1;
    mem[0] = 32'h1234_5678;
    step(2'b10, 2'b10, '0, '0, 2'b00);
    step(2'b00, 2'b00, '0, '0, 2'b00);
    step(2'b00, 2'b00, '0, '0, 2'b10);
    drain();

    // Error cases: pop on empty, push on full.
    sp = 0;
    step(2'b01, 2'b01, '0, '0, 2'b11);
    drain();
    sp = DEPTH;
    step(2'b10, 2'b00, '0, 32'hDEAD_BEEF, 2'b11);
    drain();

    // Response back-pressure for 5 cycles with both requesters pending;
    // the wrong requester's ready bit must be ignored.
    sp = 0;
    step(2'b01, 2'b00, 32'h0000_00AA, '0, 2'b00);
    step(2'b11, 2'b00, '0, '0, 2'b00);
    repeat (5) step(2'b11, 2'b00, '0, '0, 2'b10);
    step(2'b11, 2'b00, '0, '0, 2'b01);
    drain();

    // Both valid continuously: grants alternate.
    sp = 0;
    repeat (14) step(2'b11, 2'b00, $urandom, $urandom, 2'b11);
    drain();

    // Reset during ISSUE: outputs drop in the same cycle.
    sp = 0;
    step(2'b01, 2'b00, 32'h0BAD_F00D, '0, 2'b11);
    drive_stack();
    reset = 1'b0;
    #1;
    check_all_zero("reset_issue");
    m_out = 0;
    m_ptr = 0;
    bus.req_valid_i = '0;
    @(negedge clk);
    reset = 1'b1;
    step(2'b11, 2'b00, 32'h0000_0042, 32'h0000_0043, 2'b00);
    step(2'b00, 2'b00, '0, '0, 2'b00);
    step(2'b00, 2'b00, '0, '0, 2'b01);
    drain();

    // Randomized traffic against the model.
    sp = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] rr;
      rr = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      step(2'($urandom), 2'($urandom), $urandom, $urandom, rr);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
